fix_ascii_serializer: RTL and testbench

Downstream stage of the float-to-fixed ASCII path. It takes one decoded number per transaction: a sign flag, the ASCII integer digits, and the 32-bit four-character ASCII fraction produced by the fraction decoder. It emits that number as a byte stream of the form `[-]int.ffff[CR LF]` over a valid/ready character interface, for a UART TX or a character FIFO. Leading zeros of the integer part are suppressed, and backpressure is honoured with no bubbles.

---
 rtl/fix_ascii_serializer.sv | 178 +++++++++++++++++
 tb/tb_fix_ascii_serializer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_ascii_serializer.sv
// fix_ascii_serializer
// Serialises one decoded fixed-point number as "[-]int.ffff[CR LF]" over a
// valid/ready byte interface. Leading integer zeros are skipped by starting
// the digit counter at the first significant digit, so suppression costs no
// cycles. Each state owns the byte currently presented on o_char.

module fix_ascii_serializer #(
    parameter int INT_DIGITS  = 3,
    parameter bit APPEND_CRLF = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_sign,
    input  logic [8*INT_DIGITS-1:0] i_int_ascii,
    input  logic [31:0]             i_frac_ascii,
    output logic [7:0]              o_char,
    output logic                    o_char_valid,
    input  logic                    i_char_ready,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_POINT = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIGN,
        ST_INT,
        ST_POINT,
        ST_FRAC,
        ST_CR,
        ST_LF
    } state_t;

    state_t                  state;
    logic [8*INT_DIGITS-1:0] int_q;
    logic [31:0]             frac_q;
    logic [3:0]              idx;
    logic [3:0]              start_idx;
    logic                    xfer;

    assign xfer = o_char_valid && i_char_ready;

    // Integer byte 0 is the least significant digit.
    function automatic logic [7:0] int_byte(input logic [8*INT_DIGITS-1:0] digits,
                                            input logic [3:0]              sel);
        return digits[8*int'(sel) +: 8];
    endfunction

    // Fraction byte 3 is the tenths digit, byte 0 the ten-thousandths digit.
    function automatic logic [7:0] frac_byte(input logic [31:0] frac,
                                             input logic [1:0]  sel);
        return frac[8*int'(sel) +: 8];
    endfunction

    // Locate the most significant non-'0' integer digit; all zeros leaves digit 0.
    always_comb begin
        // NOTE: default assignment first so every path drives start_idx and no latch is inferred.
        start_idx = 4'd0;
        for (int i = 0; i < INT_DIGITS; i++) begin
            if (i_int_ascii[8*i +: 8] != ASCII_ZERO) begin
                start_idx = 4'(i);
            end
        end
    end

    // Payload registers, loaded on capture only.
    always_ff @(posedge i_clk) begin
        // NOTE: payload storage carries no reset; it is always rewritten before being read.
        if (o_ready && i_valid) begin
            int_q  <= i_int_ascii;
            frac_q <= i_frac_ascii;
        end
    end

    // Message sequencer: state, digit counter and all registered outputs.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        o_done <= 1'b0;
        if (i_rst) begin
            state        <= ST_IDLE;
            idx          <= 4'd0;
            o_ready      <= 1'b1;
            o_char       <= 8'h00;
            o_char_valid <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        idx          <= start_idx;
                        o_ready      <= 1'b0;
                        o_char_valid <= 1'b1;
                        o_busy       <= 1'b1;
                        if (i_sign) begin
                            state  <= ST_SIGN;
                            o_char <= ASCII_MINUS;
                        end else begin
                            state  <= ST_INT;
                            o_char <= int_byte(i_int_ascii, start_idx);
                        end
                    end
                end
                ST_SIGN: begin
                    if (xfer) begin
                        state  <= ST_INT;
                        o_char <= int_byte(int_q, idx);
                    end
                end
                ST_INT: begin
                    if (xfer) begin
                        if (idx == 4'd0) begin
                            state  <= ST_POINT;
                            o_char <= ASCII_POINT;
                        end else begin
                            idx    <= idx - 4'd1;
                            o_char <= int_byte(int_q, idx - 4'd1);
                        end
                    end
                end
                ST_POINT: begin
                    if (xfer) begin
                        state  <= ST_FRAC;
                        idx    <= 4'd3;
                        o_char <= frac_byte(frac_q, 2'd3);
                    end
                end
                ST_FRAC: begin
                    if (xfer) begin
                        if (idx == 4'd0) begin
                            if (APPEND_CRLF) begin
                                state  <= ST_CR;
                                o_char <= ASCII_CR;
                            end else begin
                                state        <= ST_IDLE;
                                o_ready      <= 1'b1;
                                o_char_valid <= 1'b0;
                                o_busy       <= 1'b0;
                                o_done       <= 1'b1;
                            end
                        end else begin
                            idx    <= idx - 4'd1;
                            o_char <= frac_byte(frac_q, idx[1:0] - 2'd1);
                        end
                    end
                end
                ST_CR: begin
                    if (xfer) begin
                        state  <= ST_LF;
                        o_char <= ASCII_LF;
                    end
                end
                ST_LF: begin
                    if (xfer) begin
                        state        <= ST_IDLE;
                        o_ready      <= 1'b1;
                        o_char_valid <= 1'b0;
                        o_busy       <= 1'b0;
                        o_done       <= 1'b1;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    o_ready      <= 1'b1;
                    o_char_valid <= 1'b0;
                    o_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fix_ascii_serializer.sv
// Self-checking bench for fix_ascii_serializer: table-driven messages,
// hand-written corner sequences (backpressure, back-to-back, reset) and
// randomized messages compared against a byte-list reference model.

module tb_fix_ascii_serializer;

    localparam int INT_DIGITS = 3;

    logic                    i_clk = 1'b0;
    logic                    i_rst;
    logic                    i_valid;
    logic                    v_nc;
    logic                    i_sign;
    logic [8*INT_DIGITS-1:0] i_int_ascii;
    logic [31:0]             i_frac_ascii;
    logic                    i_char_ready;

    logic       o_ready, o_char_valid, o_busy, o_done;
    logic [7:0] o_char;
    logic       nc_ready, nc_char_valid, nc_busy, nc_done;
    logic [7:0] nc_char;

    always #5 i_clk = ~i_clk;

    fix_ascii_serializer #(.INT_DIGITS(INT_DIGITS), .APPEND_CRLF(1'b1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_sign(i_sign), .i_int_ascii(i_int_ascii), .i_frac_ascii(i_frac_ascii),
        .o_char(o_char), .o_char_valid(o_char_valid), .i_char_ready(i_char_ready),
        .o_busy(o_busy), .o_done(o_done)
    );

    fix_ascii_serializer #(.INT_DIGITS(INT_DIGITS), .APPEND_CRLF(1'b0)) dut_nc (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(v_nc), .o_ready(nc_ready),
        .i_sign(i_sign), .i_int_ascii(i_int_ascii), .i_frac_ascii(i_frac_ascii),
        .o_char(nc_char), .o_char_valid(nc_char_valid), .i_char_ready(i_char_ready),
        .o_busy(nc_busy), .o_done(nc_done)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         done_cyc;
    int         wait_cnt;
    bit         bubble;

    typedef struct {
        logic        sign;
        logic [23:0] int_a;
        logic [31:0] frac_a;
        int          exp_len;
        logic [7:0]  exp_first;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: build the expected byte list from the formatting rules.
    function automatic void build_exp(input logic s, input logic [23:0] ia,
                                      input logic [31:0] fa, input bit crlf);
        logic [7:0] digits[$];
        logic [31:0] f;
        exp_q.delete();
        for (int d = INT_DIGITS - 1; d >= 0; d--) digits.push_back(ia[8*d +: 8]);
        while (digits.size() > 1 && digits[0] == "0") void'(digits.pop_front());
        if (s) exp_q.push_back("-");
        foreach (digits[k]) exp_q.push_back(digits[k]);
        exp_q.push_back(".");
        f = fa;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(f[31:24]);
            f = f << 8;
        end
        if (crlf) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endfunction

    task automatic compare_msg(input string name);
        check({name, "_len"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < got_q.size()) check({name, "_byte"}, got_q[k], exp_q[k]);
        end
    endtask

    // Capture one message on the main DUT and collect its bytes.
    // mode 0: ready held high, 1: pattern 1,0,0,1,0,1..., 2: random ready.
    task automatic run_msg(input logic s, input logic [23:0] ia, input logic [31:0] fa,
                           input int mode, input bit pulse);
        int         cyc;
        int         ntx;
        bit         stalled;
        bit         pulsed;
        bit         rdy;
        logic [7:0] held;
        bit         pat[6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        got_q.delete();
        done_cyc = -1;
        bubble   = 1'b0;
        stalled  = 1'b0;
        pulsed   = 1'b0;
        ntx      = 0;
        held     = 8'h00;
        wait_cnt = 0;
        while (!o_ready && wait_cnt < 50) begin
            @(negedge i_clk);
            wait_cnt++;
        end
        check("ready_before_capture", o_ready, 1'b1);
        i_sign       = s;
        i_int_ascii  = ia;
        i_frac_ascii = fa;
        i_valid      = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        cyc     = 1;
        check("first_byte_valid", o_char_valid, 1'b1);
        check("busy_after_capture", o_busy, 1'b1);
        check("ready_low_after_capture", o_ready, 1'b0);
        check("no_done_after_capture", o_done, 1'b0);
        while (cyc < 200) begin
            if (o_done) begin
                done_cyc = cyc;
                break;
            end
            if (!o_char_valid) bubble = 1'b1;
            if (stalled) begin
                check("stall_hold_valid", o_char_valid, 1'b1);
                check("stall_hold_char", o_char, held);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[(cyc - 1) % 6];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            i_char_ready = rdy;
            if (o_char_valid && rdy) begin
                got_q.push_back(o_char);
                ntx++;
            end
            stalled = o_char_valid && !rdy;
            held    = o_char;
            if (pulse && !pulsed && ntx >= 2) begin
                i_valid     = 1'b1;
                i_int_ascii = "999";
                i_sign      = 1'b1;
                pulsed      = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            @(negedge i_clk);
            cyc++;
        end
        i_valid = 1'b0;
        check("done_seen", (done_cyc != -1), 1'b1);
        check("no_bubble", bubble, 1'b0);
        check("done_ready", o_ready, 1'b1);
        check("done_busy_low", o_busy, 1'b0);
        check("done_valid_low", o_char_valid, 1'b0);
        build_exp(s, ia, fa, 1'b1);
    endtask

    vec_t vecs[6];
    int   nc_cyc;

    initial begin
        vecs[0] = '{1'b0, "123", "0625", 10, 8'h31};
        vecs[1] = '{1'b1, "007", "5000",  9, 8'h2D};
        vecs[2] = '{1'b0, "000", "0000",  8, 8'h30};
        vecs[3] = '{1'b1, "000", "1234",  9, 8'h2D};
        vecs[4] = '{1'b0, "100", "9999", 10, 8'h31};
        vecs[5] = '{1'b0, "050", "0001",  9, 8'h35};

        i_rst        = 1'b1;
        i_valid      = 1'b0;
        v_nc         = 1'b0;
        i_sign       = 1'b0;
        i_int_ascii  = '0;
        i_frac_ascii = '0;
        i_char_ready = 1'b0;

        // Reset values
        @(negedge i_clk);
        @(negedge i_clk);
        check("rst_ready", o_ready, 1'b1);
        check("rst_char", o_char, 8'h00);
        check("rst_valid", o_char_valid, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Table-driven messages with ready held high
        for (int v = 0; v < 6; v++) begin
            run_msg(vecs[v].sign, vecs[v].int_a, vecs[v].frac_a, 0, 1'b0);
            compare_msg("table");
            check("table_len_const", got_q.size(), vecs[v].exp_len);
            if (got_q.size() > 0) check("table_first_byte", got_q[0], vecs[v].exp_first);
            check("table_done_cycle", done_cyc, vecs[v].exp_len + 1);
            @(negedge i_clk);
            check("done_one_cycle", o_done, 1'b0);
            check("idle_ready", o_ready, 1'b1);
        end

        // Backpressure on the "123" message
        run_msg(1'b0, "123", "0625", 1, 1'b0);
        compare_msg("backpressure");
        @(negedge i_clk);

        // Ignored capture mid-message, then back-to-back capture in the done cycle
        run_msg(1'b0, "123", "0625", 0, 1'b1);
        compare_msg("busy_ignore");
        run_msg(1'b1, "042", "7500", 0, 1'b0);
        check("b2b_capture_in_done_cycle", wait_cnt, 0);
        compare_msg("b2b_second");
        @(negedge i_clk);

        // Reset after three transfers
        i_sign       = 1'b0;
        i_int_ascii  = "123";
        i_frac_ascii = "0625";
        i_char_ready = 1'b1;
        i_valid      = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        for (int k = 0; k < 3; k++) @(negedge i_clk);
        check("pre_reset_fourth_byte", o_char, 8'h2E);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("midrst_valid", o_char_valid, 1'b0);
        check("midrst_char", o_char, 8'h00);
        check("midrst_busy", o_busy, 1'b0);
        check("midrst_done", o_done, 1'b0);
        check("midrst_ready", o_ready, 1'b1);
        i_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check("postrst_no_done", o_done, 1'b0);
        end
        run_msg(1'b1, "007", "5000", 0, 1'b0);
        compare_msg("after_reset");
        @(negedge i_clk);

        // No CR/LF variant: six bytes, done the cycle after the sixth transfer
        i_sign       = 1'b0;
        i_int_ascii  = "000";
        i_frac_ascii = "0000";
        i_char_ready = 1'b1;
        v_nc         = 1'b1;
        @(negedge i_clk);
        v_nc   = 1'b0;
        nc_cyc = 1;
        got_q.delete();
        done_cyc = -1;
        while (nc_cyc < 40) begin
            if (nc_done) begin
                done_cyc = nc_cyc;
                break;
            end
            if (nc_char_valid) got_q.push_back(nc_char);
            @(negedge i_clk);
            nc_cyc++;
        end
        build_exp(1'b0, "000", "0000", 1'b0);
        compare_msg("nocrlf");
        check("nocrlf_done_cycle", done_cyc, 7);
        check("nocrlf_ready", nc_ready, 1'b1);
        check("nocrlf_busy", nc_busy, 1'b0);
        @(negedge i_clk);

        // Randomized messages with random backpressure
        for (int r = 0; r < 25; r++) begin
            logic        rs;
            logic [23:0] ria;
            logic [31:0] rfa;
            rs = 1'($urandom_range(0, 1));
            for (int d = 0; d < 3; d++) begin
                case ($urandom_range(0, 3))
                    0, 1:    ria[8*d +: 8] = 8'h30;
                    2:       ria[8*d +: 8] = 8'(8'h30 + $urandom_range(0, 9));
                    default: ria[8*d +: 8] = 8'($urandom_range(0, 255));
                endcase
            end
            rfa = $urandom;
            run_msg(rs, ria, rfa, 2, 1'($urandom_range(0, 1)));
            compare_msg("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
